// File: rtl/fpu_rr_arbiter_if.sv
// fpu_rr_arbiter_if: requester and FPU-adapter signals of the shared FPU arbiter
interface fpu_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*64-1:0] req_a;
  logic [NUM_REQ*64-1:0] req_b;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] resp_valid;
  logic [63:0] resp_data;
  logic resp_err;
  logic [NUM_REQ-1:0] resp_ready;
  logic [63:0] fpu_a;
  logic [63:0] fpu_b;
  logic fpu_start;
  logic [63:0] fpu_result;
  logic fpu_done;
  logic busy;
  logic [IDW-1:0] grant_id;
  modport slave (
    input req_valid, req_a, req_b, resp_ready, fpu_result, fpu_done,
    output req_ready, resp_valid, resp_data, resp_err, fpu_a, fpu_b, fpu_start, busy, grant_id
  );
  modport master (
    output req_valid, req_a, req_b, resp_ready, fpu_result, fpu_done,
    input req_ready, resp_valid, resp_data, resp_err, fpu_a, fpu_b, fpu_start, busy, grant_id
  );
endinterface

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: round-robin sharing of one FPU adapter with a completion watchdog
module fpu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256,
  parameter int IDW = $clog2(NUM_REQ)
) (
  input logic clock,
  input logic reset,
  fpu_rr_arbiter_if.slave bus
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESPOND} state_t;
  state_t state_q;
  logic [IDW-1:0] last_q, grant_q, g, idx;
  logic found;
  logic [63:0] a_sel, b_sel, fpu_a_q, fpu_b_q, resp_data_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic resp_err_q, start_q;
  logic [CW-1:0] cnt_q;
  // scan farthest-first so the requester nearest after last_q wins
  always_comb begin
    found = 1'b0;
    g = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDW'((int'(last_q) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
  end
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g == IDW'(i)) begin
        a_sel = bus.req_a[64*i +: 64];
        b_sel = bus.req_b[64*i +: 64];
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= IDW'(NUM_REQ - 1);
      grant_q <= '0;
      fpu_a_q <= '0;
      fpu_b_q <= '0;
      start_q <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q <= '0;
      resp_err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          state_q <= ISSUE;
          grant_q <= g;
          fpu_a_q <= a_sel;
          fpu_b_q <= b_sel;
          start_q <= 1'b1;
        end
        ISSUE: begin
          start_q <= 1'b0;
          cnt_q <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.fpu_done) begin
            resp_data_q <= bus.fpu_result;
            resp_err_q <= 1'b0;
            resp_valid_q <= NUM_REQ'(1) << grant_q;
            state_q <= RESPOND;
          end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
            resp_data_q <= '0;
            resp_err_q <= 1'b1;
            resp_valid_q <= NUM_REQ'(1) << grant_q;
            state_q <= RESPOND;
          end
        end
        RESPOND: if (bus.resp_ready[grant_q]) begin
          resp_valid_q <= '0;
          last_q <= grant_q;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign bus.req_ready = (state_q == IDLE && found && !reset) ? NUM_REQ'(1) << g : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data = resp_data_q;
  assign bus.resp_err = resp_err_q;
  assign bus.fpu_a = fpu_a_q;
  assign bus.fpu_b = fpu_b_q;
  assign bus.fpu_start = start_q;
  assign bus.busy = state_q != IDLE;
  assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// tb_fpu_rr_arbiter: scoreboard bench for the round-robin FPU arbiter with an FPU model
module tb_fpu_rr_arbiter;
  logic clock, reset;
  fpu_rr_arbiter_if #(.NUM_REQ(4)) bus();
  fpu_rr_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  typedef struct {int idx; logic [63:0] data; logic err;} exp_t;
  exp_t sb[$];
  int acc_q[$];
  int n_chk = 0, n_pass = 0, n_start = 0, lat = 5, cd = -1;
  logic model_done, inj_done;
  logic [63:0] model_res, res_hold;
  logic [63:0] av [4];
  logic [63:0] bv [4];
  assign bus.fpu_done = model_done | inj_done;
  assign bus.fpu_result = model_res;
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  function automatic logic [63:0] fmodel(input logic [63:0] a, input logic [63:0] b);
    return (a == 64'h3FF0000000000000 && b == 64'h4000000000000000) ? 64'h4008000000000000 : (a ^ {b[31:0], b[63:32]}) + 64'd1;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // FPU adapter model: done pulses lat cycles after the start cycle; lat 0 never completes
  initial begin
    model_done = 1'b0;
    model_res = '0;
    res_hold = '0;
    forever begin
      @(negedge clock);
      model_done = 1'b0;
      if (bus.fpu_start) begin
        cd = lat;
        res_hold = fmodel(bus.fpu_a, bus.fpu_b);
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          model_done = 1'b1;
          model_res = res_hold;
          cd = -1;
        end
      end
    end
  end
  always @(negedge clock) begin
    #2;
    for (int i = 0; i < 4; i++) if (bus.req_ready[i]) acc_q.push_back(i);
    if (bus.fpu_start) n_start++;
  end
  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[64*i +: 64] = av[i];
      bus.req_b[64*i +: 64] = bv[i];
    end
  endtask
  task automatic rst_check(input string tag);
    check({tag, "_ctl"}, {54'd0, bus.req_ready, bus.resp_valid, bus.busy, bus.fpu_start}, 64'd0);
    check({tag, "_misc"}, {61'd0, bus.grant_id, bus.resp_err}, 64'd0);
    check({tag, "_data"}, bus.resp_data, 64'd0);
    check({tag, "_fpu_a"}, bus.fpu_a, 64'd0);
    check({tag, "_fpu_b"}, bus.fpu_b, 64'd0);
  endtask
  task automatic issue(input logic [3:0] v, input int idx, input bit drop);
    bus.req_valid = v;
    #1;
    check("req_ready", 64'(bus.req_ready), 64'(4'(1 << idx)));
    @(negedge clock);
    if (drop) bus.req_valid[idx] = 1'b0;
    check("fpu_start", 64'(bus.fpu_start), 64'd1);
    check("grant_id", 64'(bus.grant_id), 64'(idx));
    check("fpu_a", bus.fpu_a, av[idx]);
    check("fpu_b", bus.fpu_b, bv[idx]);
  endtask
  task automatic collect(input int hold, input bit inj, output int waited);
    exp_t e;
    logic [3:0] m;
    waited = 0;
    while (bus.resp_valid == '0 && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("resp_arrive", 64'(bus.resp_valid != '0), 64'd1);
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (bus.resp_valid == '0 || sb.size() == 0) return;
    e = sb.pop_front();
    m = 4'(1 << e.idx);
    check("resp_valid", 64'(bus.resp_valid), 64'(m));
    check("resp_data", bus.resp_data, e.data);
    check("resp_err", 64'(bus.resp_err), 64'(e.err));
    for (int h = 0; h < hold; h++) begin
      bus.resp_ready = ~m;
      inj_done = inj && h == 0;
      @(negedge clock);
      inj_done = 1'b0;
      check("hold_data", bus.resp_data, e.data);
      check("hold_ctl", {54'd0, bus.resp_valid, bus.resp_err, bus.busy, bus.req_ready}, {54'd0, m, e.err, 1'b1, 4'b0});
    end
    bus.resp_ready = m;
    @(negedge clock);
    bus.resp_ready = '0;
    check("released", 64'(bus.resp_valid), 64'd0);
  endtask
  initial begin
    int w, a0, s0;
    bus.req_valid = '0;
    bus.resp_ready = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    inj_done = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    rst_check("rst");
    reset = 1'b0;
    av[2] = 64'h3FF0000000000000;
    bv[2] = 64'h4000000000000000;
    load_ops();
    lat = 5;
    sb.push_back('{2, 64'h4008000000000000, 1'b0});
    a0 = acc_q.size();
    s0 = n_start;
    issue(4'b0100, 2, 1);
    collect(3, 0, w);
    check("single_lat", 64'(w), 64'd6);
    check("single_accepts", 64'(acc_q.size() - a0), 64'd1);
    check("single_starts", 64'(n_start - s0), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      av[i] = {32'hA5A50000, 32'(i)};
      bv[i] = {32'h0000C3C3, 32'(i * 7 + 1)};
    end
    load_ops();
    lat = 3;
    for (int k = 0; k < 8; k++) sb.push_back('{k % 4, fmodel(av[k % 4], bv[k % 4]), 1'b0});
    a0 = acc_q.size();
    bus.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) collect(0, 0, w);
    bus.req_valid = '0;
    check("rr_count", 64'(acc_q.size() - a0), 64'd8);
    for (int k = 0; k < 8 && a0 + k < acc_q.size(); k++) check("rr_order", 64'(acc_q[a0 + k]), 64'(k % 4));
    sb.push_back('{1, fmodel(av[1], bv[1]), 1'b0});
    sb.push_back('{3, fmodel(av[3], bv[3]), 1'b0});
    issue(4'b1010, 1, 1);
    collect(10, 0, w);
    collect(0, 0, w);
    bus.req_valid = '0;
    lat = 0;
    sb.push_back('{0, 64'd0, 1'b1});
    issue(4'b0001, 0, 1);
    collect(3, 1, w);
    check("wd_lat", 64'(w), 64'd17);
    inj_done = 1'b1;
    @(negedge clock);
    inj_done = 1'b0;
    check("late_done_idle", {59'd0, bus.busy, bus.resp_valid}, 64'd0);
    lat = 16;
    sb.push_back('{1, fmodel(av[1], bv[1]), 1'b0});
    issue(4'b0010, 1, 1);
    collect(0, 0, w);
    check("coll_lat", 64'(w), 64'd17);
    lat = 0;
    issue(4'b1100, 2, 0);
    repeat (3) @(negedge clock);
    check("mid_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    rst_check("mid_rst");
    lat = 5;
    sb.push_back('{2, fmodel(av[2], bv[2]), 1'b0});
    reset = 1'b0;
    #1;
    check("post_rst_grant", 64'(bus.req_ready), 64'(4'b0100));
    @(negedge clock);
    bus.req_valid = '0;
    collect(0, 0, w);
    check("post_rst_lat", 64'(w), 64'd6);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_chk);
    $fatal(1);
  end
endmodule
